// File: rtl/sysarray_feed_ctrl.sv
// sysarray_feed_ctrl: feed sequencer for an N x N systolic multiply array.
// Holds A (N x K) and B (K x N) banks. On start it streams skewed A rows (west edge)
// and skewed B columns (north edge) for S = K + 2(N-1) cycles. It then waits DRAIN_CYC
// cycles and pulses done.
// Ports: clock, reset (sync, active-high); wr_en/wr_sel/wr_addr/wr_data bank writes;
// start; busy, feed_valid, feed_a/feed_b/feed_c (N*W each), done, wr_err.
// Optional macro SYSARRAY_FEED_CTRL_ABORT_EN adds the abort input.
module sysarray_feed_ctrl #(
  parameter int W = 32,
  parameter int N = 3,
  parameter int K = 3,
  parameter int DRAIN_CYC = 4
) (
  input  logic                     clock,
  input  logic                     reset,
`ifdef SYSARRAY_FEED_CTRL_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [$clog2(N*K)-1:0]   wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     feed_valid,
  output logic [N*W-1:0]           feed_a,
  output logic [N*W-1:0]           feed_b,
  output logic [N*W-1:0]           feed_c,
  output logic                     done,
  output logic                     wr_err
);
  localparam int S  = K + 2*(N-1);
  localparam int SW = $clog2(S+1);
  localparam int DW = $clog2(DRAIN_CYC+1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [SW-1:0] step, step_n;
  logic [DW-1:0] drain, drain_n;
  logic [W-1:0] a_bank [N*K];
  logic [W-1:0] b_bank [N*K];
  logic [W-1:0] a_n [N*K];
  logic [W-1:0] b_n [N*K];
  logic [N*W-1:0] fa_r, fb_r, fa_n, fb_n;
  logic wr_ok, stop;
`ifdef SYSARRAY_FEED_CTRL_ABORT_EN
  assign stop = abort && busy;
`else
  assign stop = 1'b0;
`endif
  // a_n/b_n are the banks with this cycle's accepted write applied, so a write
  // issued together with start is already visible to step 0.
  always_comb begin
    wr_ok = wr_en && (state == IDLE || state == DONE) && 32'(wr_addr) < N*K;
    a_n = a_bank;
    b_n = b_bank;
    if (wr_ok && !wr_sel) a_n[wr_addr] = wr_data;
    if (wr_ok && wr_sel) b_n[wr_addr] = wr_data;
  end
  always_comb begin
    state_n = state;
    step_n = '0;
    drain_n = '0;
    case (state)
      IDLE: state_n = start ? FEED : IDLE;
      FEED: if (step == SW'(S-1)) state_n = DRAIN; else step_n = step + 1'b1;
      DRAIN: if (drain == DW'(DRAIN_CYC-1)) state_n = DONE; else drain_n = drain + 1'b1;
      default: state_n = IDLE;
    endcase
    if (stop) state_n = IDLE;
  end
  // Row i carries A[i][s-i] and column j carries B[s-j][j]; the match on the
  // constant diagonal index i+k keeps every bank select static.
  always_comb begin
    fa_n = '0;
    fb_n = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++)
        if (step_n == SW'(i+k)) begin
          fa_n[i*W +: W] = a_n[i*K+k];
          fb_n[i*W +: W] = b_n[k*N+i];
        end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      step <= '0;
      drain <= '0;
      fa_r <= '0;
      fb_r <= '0;
      wr_err <= 1'b0;
      for (int i = 0; i < N*K; i++) begin
        a_bank[i] <= '0;
        b_bank[i] <= '0;
      end
    end else begin
      state <= state_n;
      step <= step_n;
      drain <= drain_n;
      fa_r <= (state_n == FEED) ? fa_n : '0;
      fb_r <= (state_n == FEED) ? fb_n : '0;
      wr_err <= wr_en && !wr_ok;
      a_bank <= a_n;
      b_bank <= b_n;
    end
  end
  assign busy = state == FEED || state == DRAIN;
  assign feed_valid = state == FEED && !stop;
  assign feed_a = stop ? '0 : fa_r;
  assign feed_b = stop ? '0 : fb_r;
  assign feed_c = '0;
  assign done = state == DONE;
endmodule

// File: tb/tb_sysarray_feed_ctrl.sv
// tb_sysarray_feed_ctrl: directed plus randomized bench for sysarray_feed_ctrl.
module tb_sysarray_feed_ctrl;
  localparam int W = 32, N = 3, K = 3, D = 4, S = K + 2*(N-1);
  localparam int NW = N*W;
  logic clock = 0, reset = 1, wr_en = 0, wr_sel = 0, start = 0;
  logic [3:0] wr_addr = 0;
  logic [W-1:0] wr_data = 0;
  logic busy, feed_valid, done, wr_err;
  logic [NW-1:0] feed_a, feed_b, feed_c;
`ifdef SYSARRAY_FEED_CTRL_ABORT_EN
  logic abort = 0;
`endif
  int nvec = 0, nerr = 0;
  logic [W-1:0] ma [N*K];
  logic [W-1:0] mb [N*K];
  logic [W-1:0] ha [S][N];
  logic [W-1:0] hb [S][N];

  always #5 clock = ~clock;

  sysarray_feed_ctrl #(.W(W), .N(N), .K(K), .DRAIN_CYC(D)) dut (
    .clock(clock), .reset(reset),
`ifdef SYSARRAY_FEED_CTRL_ABORT_EN
    .abort(abort),
`endif
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .feed_valid(feed_valid),
    .feed_a(feed_a), .feed_b(feed_b), .feed_c(feed_c),
    .done(done), .wr_err(wr_err)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] exp_a(input int s);
    logic [NW-1:0] v = '0;
    for (int i = 0; i < N; i++) if (s-i >= 0 && s-i < K) v[i*W +: W] = ma[i*K + s-i];
    return v;
  endfunction

  function automatic logic [NW-1:0] exp_b(input int s);
    logic [NW-1:0] v = '0;
    for (int j = 0; j < N; j++) if (s-j >= 0 && s-j < K) v[j*W +: W] = mb[(s-j)*N + j];
    return v;
  endfunction

  task automatic wr(input logic sel, input int addr, input logic [W-1:0] d);
    bit drop = addr >= N*K;
    wr_en = 1; wr_sel = sel; wr_addr = 4'(addr); wr_data = d;
    tick;
    wr_en = 0;
    if (!drop) begin
      if (sel) mb[addr] = d; else ma[addr] = d;
    end
    chk("wr_err", NW'(wr_err), NW'(drop));
  endtask

  task automatic load_rand;
    for (int a = 0; a < N*K; a++) begin
      wr(0, a, $urandom);
      wr(1, a, $urandom);
    end
  endtask

  // One full sequence checked cycle by cycle; the product of the observed skewed
  // streams, as a PE grid would accumulate it, must equal A*B from the model banks.
  task automatic run_seq(input bit dup, input bit drain_wr, input bit same_wr);
    logic [W-1:0] got, want;
    start = 1;
    if (same_wr) begin
      wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = $urandom;
      ma[0] = wr_data;
    end
    for (int c = 1; c <= S+D+2; c++) begin
      tick;
      wr_en = 0;
      start = dup && c == 3;
`ifdef SYSARRAY_FEED_CTRL_ABORT_EN
      abort = 0;
`endif
      chk("feed_valid", NW'(feed_valid), NW'(c <= S));
      chk("busy", NW'(busy), NW'(c <= S+D));
      chk("done", NW'(done), NW'(c == S+D+1));
      chk("wr_err_seq", NW'(wr_err), NW'(drain_wr && c == S+3));
      chk("feed_a", feed_a, c <= S ? exp_a(c-1) : '0);
      chk("feed_b", feed_b, c <= S ? exp_b(c-1) : '0);
      chk("feed_c", feed_c, '0);
      if (c <= S)
        for (int i = 0; i < N; i++) begin
          ha[c-1][i] = feed_a[i*W +: W];
          hb[c-1][i] = feed_b[i*W +: W];
        end
      if (drain_wr && c == S+2) begin
        wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = 99;
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        got = '0;
        want = '0;
        for (int t = 0; t < S+2*N; t++)
          if (t-j >= 0 && t-j < S && t-i >= 0 && t-i < S) got += ha[t-j][i] * hb[t-i][j];
        for (int k = 0; k < K; k++) want += ma[i*K+k] * mb[k*N+j];
        chk("c_out", NW'(got), NW'(want));
      end
  endtask

  initial begin
    repeat (2) tick;
    reset = 0;
    chk("rst_busy", NW'(busy), '0);
    chk("rst_valid", NW'(feed_valid), '0);
    chk("rst_done", NW'(done), '0);
    chk("rst_wr_err", NW'(wr_err), '0);
    chk("rst_feed_a", feed_a, '0);
    chk("rst_feed_b", feed_b, '0);
    chk("rst_feed_c", feed_c, '0);
    for (int a = 0; a < N*K; a++) begin
      wr(0, a, W'(a+1));
      wr(1, a, W'(a/N == a%N));
    end
    run_seq(1, 1, 0);
    run_seq(0, 0, 0);
    wr(0, 9, 123);
    wr(1, 9, 5);
    run_seq(0, 0, 0);
    start = 1;
    tick;
    start = 0;
    repeat (4) tick;
    chk("pre_rst_valid", NW'(feed_valid), 1);
    chk("pre_rst_feed_a", feed_a, exp_a(4));
    reset = 1;
    tick;
    reset = 0;
    chk("mid_rst_busy", NW'(busy), '0);
    chk("mid_rst_feed_a", feed_a, '0);
    chk("mid_rst_feed_b", feed_b, '0);
    for (int a = 0; a < N*K; a++) begin
      ma[a] = '0;
      mb[a] = '0;
    end
    repeat (S+D+2) begin
      tick;
      chk("mid_rst_done", NW'(done), '0);
    end
    run_seq(0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      load_rand();
      run_seq(0, 0, r == 1);
    end
`ifdef SYSARRAY_FEED_CTRL_ABORT_EN
    start = 1;
    tick;
    start = 0;
    repeat (2) tick;
    chk("pre_abort_feed_a", feed_a, exp_a(2));
    abort = 1;
    #1;
    chk("abort_feed_a", feed_a, '0);
    chk("abort_feed_b", feed_b, '0);
    tick;
    abort = 0;
    chk("abort_busy", NW'(busy), '0);
    start = 1;
    tick;
    start = 0;
    repeat (S+1) tick;
    abort = 1;
    tick;
    abort = 0;
    chk("abort_drain_busy", NW'(busy), '0);
    chk("abort_drain_done", NW'(done), '0);
    repeat (D+2) begin
      tick;
      chk("abort_no_done", NW'(done), '0);
    end
    run_seq(0, 0, 0);
    abort = 1;
    run_seq(0, 0, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
